reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
- Writer-side companion to the 16x16 register file: collects results from two producers (single-cycle ALU, multi-cycle memory unit) and drives the register file write port (wR, writeEnable, datain).
- Buffers results in an in-order FIFO, retires at most one write per cycle and exposes pending-write (busy) flags for two read addresses so decode can stall on RAW hazards.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width (16 registers).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  memory result offered.
- mem_ready  out  1  memory result accepted this cycle.
- mem_rd  in  ADDR_W  memory destination register.
- mem_data  in  DATA_W  memory result.
- wb_hold  in  1  write port unavailable; no retire this cycle.
- flush  in  1  synchronous discard of all queued entries.
- wR  out  ADDR_W  register file write address.
- writeEnable  out  1  register file write strobe.
- datain  out  DATA_W  register file write data.
- chk_reg1  in  ADDR_W  first read address to check.
- chk_reg2  in  ADDR_W  second read address to check.
- busy1  out  1  a queued entry targets chk_reg1.
- busy2  out  1  a queued entry targets chk_reg2.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count go to 0. FSM goes to IDLE. writeEnable=0, wR=0, datain=0, busy1=busy2=0.
- Enqueue:
  - At most one push per edge. Memory has priority.
  - mem_ready = !full & !flush.
  - alu_ready = !full & !flush & !mem_valid.
  - Push occurs when valid & ready are both high at the edge.
  - A producer holds valid, rd and data stable until its ready is seen.
- Retire:
  - writeEnable = !empty & !wb_hold & !flush. wR and datain equal the FIFO head (combinational from registered head).
  - The head pops on any edge where writeEnable=1. The register file writes on that same edge.
  - Latency: push at edge N gives a retire at edge N+1 when the queue was empty and there is no hold.
  - When empty, wR and datain hold their last values.
- Full: ready stays low even if a pop occurs in the same cycle (no pass-through at full).
- Simultaneous push and pop: count is unchanged. Order is preserved.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full/empty are derived from count.
- FSM:
  - IDLE (count=0) -> DRAIN on push.
  - DRAIN -> HOLD when wb_hold=1.
  - HOLD -> DRAIN when wb_hold=0.
  - DRAIN -> IDLE when the last entry pops with no push.
  - Any state -> IDLE on flush.
- Flush: at the edge, count and pointers clear and no write or push occurs. Flush has priority over push, pop and hold.
- Busy flags:
  - busyN = 1 if any valid FIFO entry has rd == chk_regN.
  - Combinational over stored entries only; in-flight producer inputs are excluded.
  - Register 0 is not special.
- Duplicate destinations in the queue are legal. They retire in order, so the last write wins.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when the queue is empty and wb_hold=0 and flush=0, an accepted producer result drives wR, datain and writeEnable combinationally in the same cycle and is not stored (latency 0). Memory still has priority. busy flags are unaffected.
- Undefined: every result passes through the FIFO; minimum latency 1 cycle.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and ADDR_W constants.
  - wb_entry_t struct {rd, data}.
  - wb_state_t enum {IDLE, DRAIN, HOLD}.
- Sub-module wb_fifo: storage, pointers, count, and per-entry rd/valid vectors for the busy compare. The top holds arbitration, FSM and bypass.

Test Plan:
- ALU push rd=3 data=16'hBEEF on an empty queue, no hold -> next edge: writeEnable=1, wR=3, datain=BEEF; count returns to 0; with WB_BYPASS_EN the write occurs in the same cycle.
- mem_valid and alu_valid together (mem rd=5 data=1111, alu rd=6 data=2222) -> mem accepted first with alu_ready=0; next cycle ALU accepted; writes retire in order 5 then 6.
- wb_hold=1 while pushing 4 entries -> count=4, both readys 0, writeEnable=0; release hold -> 4 consecutive writes in FIFO order; pointers wrap correctly on a refill.
- Queue holds rd=7 and chk_reg1=7, chk_reg2=2 -> busy1=1, busy2=0; after the rd=7 entry retires -> busy1=0.
- Push rd=4 data=AAAA, then rd=4 data=BBBB -> two writes; the final register 4 value is BBBB.
- Flush with 3 entries held, and separately rst_n low mid-drain -> count=0, writeEnable=0 immediately (reset asynchronously), no further writes, busy flags 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: widths, writeback entry and writeback FSM state shared by the
// register file writeback path.
package regfile_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order result storage with pointers, occupancy count and
// per-entry destination/valid vectors for hazard checking.
module wb_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ADDR_W-1:0]       push_rd,
    input  logic [DATA_W-1:0]       push_data,
    output logic [ADDR_W-1:0]       head_rd,
    output logic [DATA_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic [ADDR_W-1:0]       ent_rd [DEPTH],
    output logic [DEPTH-1:0]        ent_vld
);
    import regfile_pkg::*;
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] count_q, count_d;
    logic [ADDR_W-1:0] rd_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    always_comb begin
        wr_ptr_d = clr ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = clr ? '0 : rd_ptr_q + PW'(pop);
        count_d  = clr ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            rd_mem_q[wr_ptr_q]   <= push_rd;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end
    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_vld[i] = {1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q;
    end
    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign ent_rd    = rd_mem_q;
    assign count     = count_q;
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: arbitrates ALU/memory results into an in-order queue
// driving the register file write port. WB_BYPASS_EN enables empty-queue bypass.
module reg_writeback_queue #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDR_W-1:0]       mem_rd,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    wb_hold,
    input  logic                    flush,
    output logic [ADDR_W-1:0]       wR,
    output logic                    writeEnable,
    output logic [DATA_W-1:0]       datain,
    input  logic [ADDR_W-1:0]       chk_reg1,
    input  logic [ADDR_W-1:0]       chk_reg2,
    output logic                    busy1,
    output logic                    busy2,
    output logic [$clog2(DEPTH):0]  count
);
    import regfile_pkg::wb_state_t, regfile_pkg::IDLE, regfile_pkg::DRAIN, regfile_pkg::HOLD;
    localparam int CW = $clog2(DEPTH) + 1;
    wb_state_t state_q, state_d;
    logic full, empty, mem_acc, alu_acc, push, pop, byp;
    logic [ADDR_W-1:0] in_rd, head_rd, last_rd_q, last_rd_d;
    logic [DATA_W-1:0] in_data, head_data, last_data_q, last_data_d;
    logic [ADDR_W-1:0] ent_rd [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign mem_ready = !full && !flush;
    assign alu_ready = mem_ready && !mem_valid;
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_acc   = alu_valid && alu_ready;
    assign in_rd     = mem_acc ? mem_rd : alu_rd;
    assign in_data   = mem_acc ? mem_data : alu_data;
    assign pop       = !empty && !wb_hold && !flush;
`ifdef WB_BYPASS_EN
    assign byp = empty && !wb_hold && !flush && (mem_acc || alu_acc);
`else
    assign byp = 1'b0;
`endif
    assign push        = (mem_acc || alu_acc) && !byp;
    assign writeEnable = pop || byp;
    // The write port keeps showing the last retired write while the queue is empty.
    assign wR     = byp ? in_rd : (empty ? last_rd_q : head_rd);
    assign datain = byp ? in_data : (empty ? last_data_q : head_data);
    wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .clr(flush), .push(push), .pop(pop),
        .push_rd(in_rd), .push_data(in_data), .head_rd(head_rd), .head_data(head_data),
        .count(count), .ent_rd(ent_rd), .ent_vld(ent_vld)
    );
    always_comb begin
        last_rd_d   = writeEnable ? wR : last_rd_q;
        last_data_d = writeEnable ? datain : last_data_q;
        state_d     = state_q;
        unique case (state_q)
            IDLE:    state_d = push ? DRAIN : IDLE;
            DRAIN:   state_d = wb_hold ? HOLD : (pop && !push && count == CW'(1)) ? IDLE : DRAIN;
            HOLD:    state_d = wb_hold ? HOLD : DRAIN;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_rd_q   <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            last_rd_q   <= last_rd_d;
            last_data_q <= last_data_d;
        end
    end
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy1 = busy1 | (ent_vld[i] && ent_rd[i] == chk_reg1);
            busy2 = busy2 | (ent_vld[i] && ent_rd[i] == chk_reg2);
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed stimulus with a scoreboard of expected
// register file writes, checked by immediate assertions.
module tb_reg_writeback_queue;
    logic clk = 1'b0, rst_n;
    logic alu_valid, alu_ready, mem_valid, mem_ready, wb_hold, flush;
    logic writeEnable, busy1, busy2;
    logic [3:0] alu_rd, mem_rd, wR, chk_reg1, chk_reg2;
    logic [15:0] alu_data, mem_data, datain;
    logic [2:0] count;
    int checks = 0, errors = 0;
    regfile_pkg::wb_entry_t exp_q[$];
    regfile_pkg::wb_entry_t e;
    logic [15:0] rf [16];

    reg_writeback_queue dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_hold(wb_hold), .flush(flush), .wR(wR), .writeEnable(writeEnable), .datain(datain),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .busy1(busy1), .busy2(busy2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one result from a single producer until accepted; expected write is queued on acceptance.
    task automatic push(input logic m, input logic [3:0] rd, input logic [15:0] d);
        mem_valid = m; alu_valid = !m;
        mem_rd = rd; alu_rd = rd; mem_data = d; alu_data = d;
        for (int n = 0; n < 20; n++) begin
            #2;
            if (m ? mem_ready : alu_ready) begin
                exp_q.push_back('{rd, d});
                tick();
                mem_valid = 1'b0; alu_valid = 1'b0;
                return;
            end
            tick();
        end
        check("push_timeout", m ? mem_ready : alu_ready, 1);
        mem_valid = 1'b0; alu_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 20 && (count != 0 || exp_q.size() != 0); n++) tick();
        check("drain_count", count, 0);
        check("drain_scoreboard", exp_q.size(), 0);
    endtask

    // Every observed write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n && writeEnable) begin
            if (exp_q.size() == 0) check("spurious_write", writeEnable, 0);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", wR, e.rd);
                check("wr_data", datain, e.data);
                rf[wR] = datain;
            end
        end
    end

    initial begin
        rst_n = 1'b0; alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0;
        alu_data = 0; mem_data = 0; wb_hold = 0; flush = 0; chk_reg1 = 0; chk_reg2 = 0;
        #8;
        check("rst_count", count, 0);
        check("rst_we", writeEnable, 0);
        check("rst_wr", wR, 0);
        check("rst_datain", datain, 0);
        check("rst_busy1", busy1, 0);
        check("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        tick();

        push(1'b0, 4'd3, 16'hBEEF);
`ifdef WB_BYPASS_EN
        check("t1_count", count, 0);
        #2 check("t1_we", writeEnable, 0);
`else
        check("t1_count", count, 1);
        #2;
        check("t1_we", writeEnable, 1);
        check("t1_wr", wR, 3);
        check("t1_datain", datain, 16'hBEEF);
`endif
        tick();
        check("t1_drained", count, 0);

        mem_valid = 1; mem_rd = 5; mem_data = 16'h1111;
        alu_valid = 1; alu_rd = 6; alu_data = 16'h2222;
        #2;
        check("arb_mem_ready", mem_ready, 1);
        check("arb_alu_blocked", alu_ready, 0);
        exp_q.push_back('{4'd5, 16'h1111});
        tick();
        mem_valid = 0;
        #2;
        check("arb_alu_ready", alu_ready, 1);
        exp_q.push_back('{4'd6, 16'h2222});
        tick();
        alu_valid = 0;
        wait_empty();

        for (int r = 0; r < 2; r++) begin
            wb_hold = 1;
            for (int k = 0; k < 4; k++) push(k[0], 4'(8 + k), 16'(16'h0A00 + 16'(r * 16 + k)));
            check("hold_count", count, 4);
            mem_valid = 1; alu_valid = 1;
            #2;
            check("full_mem_ready", mem_ready, 0);
            check("full_alu_ready", alu_ready, 0);
            check("hold_we", writeEnable, 0);
            tick();
            mem_valid = 0; alu_valid = 0; wb_hold = 0;
            for (int k = 0; k < 4; k++) begin
                #2 check("release_we", writeEnable, 1);
                tick();
            end
            check("release_count", count, 0);
            check("release_scoreboard", exp_q.size(), 0);
        end

        wb_hold = 1; chk_reg1 = 7; chk_reg2 = 2;
        push(1'b0, 4'd7, 16'h7777);
        push(1'b1, 4'd1, 16'h0101);
        check("busy1_set", busy1, 1);
        check("busy2_clear", busy2, 0);
        chk_reg2 = 1;
        #1 check("busy2_set", busy2, 1);
        wb_hold = 0;
        tick();
        check("busy1_retired", busy1, 0);
        check("busy_count", count, 1);
        wait_empty();

        push(1'b0, 4'd4, 16'hAAAA);
        push(1'b0, 4'd4, 16'hBBBB);
        wait_empty();
        check("dup_last_wins", rf[4], 16'hBBBB);

        wb_hold = 1; chk_reg1 = 9;
        push(1'b0, 4'd9, 16'h0909);
        push(1'b1, 4'd10, 16'h1010);
        push(1'b0, 4'd11, 16'h1111);
        check("flush_pre_count", count, 3);
        check("flush_pre_busy", busy1, 1);
        flush = 1;
        #1;
        check("flush_we", writeEnable, 0);
        check("flush_mem_ready", mem_ready, 0);
        exp_q.delete();
        tick();
        flush = 0; wb_hold = 0;
        check("flush_count", count, 0);
        check("flush_busy", busy1, 0);
        for (int k = 0; k < 3; k++) begin
            #2 check("post_flush_we", writeEnable, 0);
            tick();
        end

        wb_hold = 1; chk_reg1 = 3;
        push(1'b0, 4'd2, 16'h0202);
        push(1'b0, 4'd3, 16'h0303);
        push(1'b1, 4'd5, 16'h0505);
        wb_hold = 0;
        tick();
        rst_n = 0;
        exp_q.delete();
        #1;
        check("arst_count", count, 0);
        check("arst_we", writeEnable, 0);
        check("arst_wr", wR, 0);
        check("arst_datain", datain, 0);
        check("arst_busy", busy1, 0);
        #1 rst_n = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            #2 check("post_rst_we", writeEnable, 0);
            tick();
        end

        check("rf5", rf[5], 16'h1111);
        check("rf6", rf[6], 16'h2222);
        check("final_scoreboard", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
